// File: rtl/spi_flash_emu.sv
// SPI NOR flash emulator: an oversampling slave that serves 03/0B/BB/EB reads from a byte-wide memory port.
// Define SPI_FLASH_EMU_QUAD_EN to support 0xEB and drive IO2/IO3; otherwise the quad datapath is removed.
module spi_flash_emu #(
    parameter int ADDR_WIDTH = 24,
    parameter int DUMMY_FAST = 8,
    parameter int DUMMY_DUAL = 0,
    parameter int DUMMY_QUAD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_csn,
    input  logic                  spi_clk,
    input  logic [3:0]            spi_io_i,
    output logic [3:0]            spi_io_o,
    output logic [3:0]            spi_io_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    input  logic [7:0]            mem_rdata,
    output logic                  powered_up,
    output logic                  xip_active
);
`ifdef SPI_FLASH_EMU_QUAD_EN
    localparam int         LANES    = 4;
    localparam logic [1:0] LN_4     = 2'd2;
    localparam logic [7:0] CMD_QUAD = 8'hEB;
`else
    localparam int LANES = 2;
    logic w_unused_io;
    assign w_unused_io = ^spi_io_i[3:2];
`endif
    localparam logic [2:0] ST_IDLE = 3'd0, ST_CMD = 3'd1, ST_ADDR = 3'd2, ST_MODE = 3'd3,
                           ST_DUMMY = 3'd4, ST_DATA = 3'd5, ST_IGNORE = 3'd6;
    localparam logic [7:0] CMD_READ = 8'h03, CMD_FAST = 8'h0B, CMD_DUAL = 8'hBB,
                           CMD_RES = 8'hAB, CMD_PD = 8'hB9, CMD_XIP_RST = 8'hFF, XIP_MODE = 8'hA5;
    localparam logic [1:0] LN_1 = 2'd0, LN_2 = 2'd1;

    logic [1:0]            r_csn_s, r_sck_s;
    logic [LANES-1:0]      r_io_s0, r_io_s1;
    logic                  r_sck_d;
    logic [2:0]            r_state;
    logic [7:0]            r_cmd, r_xip_cmd, r_cnt, r_buf, r_sh;
    logic [6:0]            r_sr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_re, r_re_d, r_powered_up, r_xip_active;
    logic [LANES-1:0]      r_o, r_oe;

    logic                  w_csn, w_rise, w_fall;
    logic [1:0]            w_lanes;
    logic [7:0]            w_step, w_cnt_nx, w_sr_nx, w_src, w_sh_nx, w_dummy_len;
    logic [ADDR_WIDTH-1:0] w_addr_nx;
    logic [LANES-1:0]      w_out, w_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csn_s <= 2'b11;
            r_sck_s <= 2'b00;
            r_io_s0 <= '0;
            r_io_s1 <= '0;
            r_sck_d <= 1'b0;
        end else begin
            r_csn_s <= {r_csn_s[0], spi_csn};
            r_sck_s <= {r_sck_s[0], spi_clk};
            r_io_s0 <= spi_io_i[LANES-1:0];
            r_io_s1 <= r_io_s0;
            r_sck_d <= r_sck_s[1];
        end
    end

    assign w_csn  = r_csn_s[1];
    assign w_rise = r_sck_s[1] & ~r_sck_d;
    assign w_fall = ~r_sck_s[1] & r_sck_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_lanes = LN_1;
        if (r_state != ST_CMD) begin
            if (r_cmd == CMD_DUAL) w_lanes = LN_2;
`ifdef SPI_FLASH_EMU_QUAD_EN
            else if (r_cmd == CMD_QUAD) w_lanes = LN_4;
`endif
        end
        w_dummy_len = 8'(DUMMY_FAST);
        if (r_cmd == CMD_DUAL) w_dummy_len = 8'(DUMMY_DUAL);
`ifdef SPI_FLASH_EMU_QUAD_EN
        else if (r_cmd == CMD_QUAD) w_dummy_len = 8'(DUMMY_QUAD);
`endif
        // A byte starts from the prefetched buffer, later bits from the shifter.
        w_src     = (r_cnt == 8'd0) ? r_buf : r_sh;
        w_step    = 8'd1;
        w_sr_nx   = {r_sr[6:0], r_io_s1[0]};
        w_addr_nx = {r_mem_addr[ADDR_WIDTH-2:0], r_io_s1[0]};
        w_sh_nx   = {w_src[6:0], 1'b0};
        w_out     = '0;
        w_mask    = '0;
        w_out[1]  = w_src[7];
        w_mask[1] = 1'b1;
        case (w_lanes)
            LN_2: begin
                w_step      = 8'd2;
                w_sr_nx     = {r_sr[5:0], r_io_s1[1:0]};
                w_addr_nx   = {r_mem_addr[ADDR_WIDTH-3:0], r_io_s1[1:0]};
                w_sh_nx     = {w_src[5:0], 2'b00};
                w_out[1:0]  = w_src[7:6];
                w_mask[1:0] = 2'b11;
            end
`ifdef SPI_FLASH_EMU_QUAD_EN
            LN_4: begin
                w_step    = 8'd4;
                w_sr_nx   = {r_sr[3:0], r_io_s1};
                w_addr_nx = {r_mem_addr[ADDR_WIDTH-5:0], r_io_s1};
                w_sh_nx   = {w_src[3:0], 4'b0000};
                w_out     = w_src[7:4];
                w_mask    = 4'b1111;
            end
`endif
            default: ;
        endcase
        w_cnt_nx = r_cnt + w_step;
    end

    // NOTE: non-blocking assignments throughout; a later assignment in the same cycle overrides an earlier default.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cmd        <= 8'h00;
            r_xip_cmd    <= 8'h00;
            r_cnt        <= 8'h00;
            r_sr         <= 7'h00;
            r_buf        <= 8'h00;
            r_sh         <= 8'h00;
            r_mem_addr   <= '0;
            r_mem_re     <= 1'b0;
            r_re_d       <= 1'b0;
            r_powered_up <= 1'b1;
            r_xip_active <= 1'b0;
            r_o          <= '0;
            r_oe         <= '0;
        end else begin
            r_mem_re <= 1'b0;
            r_re_d   <= r_mem_re;
            if (r_re_d) r_buf <= mem_rdata;
            if (w_csn) begin
                r_state <= ST_IDLE;
                r_cnt   <= 8'h00;
                r_o     <= '0;
                r_oe    <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cnt <= 8'h00;
                        if (r_xip_active && r_powered_up) begin
                            r_state <= ST_ADDR;
                            r_cmd   <= r_xip_cmd;
                        end else begin
                            r_state <= ST_CMD;
                        end
                    end
                    ST_CMD: if (w_rise) begin
                        r_sr  <= w_sr_nx[6:0];
                        r_cnt <= w_cnt_nx;
                        if (w_cnt_nx == 8'd8) begin
                            r_cnt   <= 8'h00;
                            r_cmd   <= w_sr_nx;
                            r_state <= ST_IGNORE;
                            if (w_sr_nx == CMD_RES) r_powered_up <= 1'b1;
                            else if (r_powered_up) begin
                                if (w_sr_nx == CMD_PD) r_powered_up <= 1'b0;
                                else if (w_sr_nx == CMD_XIP_RST) r_xip_active <= 1'b0;
                                else if (w_sr_nx == CMD_READ || w_sr_nx == CMD_FAST
`ifdef SPI_FLASH_EMU_QUAD_EN
                                         || w_sr_nx == CMD_QUAD
`endif
                                         || w_sr_nx == CMD_DUAL) r_state <= ST_ADDR;
                            end
                        end
                    end
                    ST_ADDR: if (w_rise) begin
                        r_mem_addr <= w_addr_nx;
                        r_cnt      <= w_cnt_nx;
                        if (w_cnt_nx == 8'd24) begin
                            r_cnt <= 8'h00;
                            if (w_lanes != LN_1) r_state <= ST_MODE;
                            else if (r_cmd == CMD_FAST && w_dummy_len != 8'd0) r_state <= ST_DUMMY;
                            else begin
                                r_state  <= ST_DATA;
                                r_mem_re <= 1'b1;
                            end
                        end
                    end
                    ST_MODE: if (w_rise) begin
                        r_sr  <= w_sr_nx[6:0];
                        r_cnt <= w_cnt_nx;
                        if (w_cnt_nx == 8'd8) begin
                            r_cnt        <= 8'h00;
                            r_xip_active <= (w_sr_nx == XIP_MODE);
                            r_xip_cmd    <= r_cmd;
                            if (w_dummy_len != 8'd0) r_state <= ST_DUMMY;
                            else begin
                                r_state  <= ST_DATA;
                                r_mem_re <= 1'b1;
                            end
                        end
                    end
                    ST_DUMMY: if (w_rise) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt + 8'd1 == w_dummy_len) begin
                            r_cnt    <= 8'h00;
                            r_state  <= ST_DATA;
                            r_mem_re <= 1'b1;
                        end
                    end
                    ST_DATA: if (w_fall) begin
                        r_o   <= w_out;
                        r_oe  <= w_mask;
                        r_sh  <= w_sh_nx;
                        r_cnt <= (w_cnt_nx == 8'd8) ? 8'h00 : w_cnt_nx;
                        if (r_cnt == 8'd0) begin
                            r_mem_re   <= 1'b1;
                            r_mem_addr <= r_mem_addr + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_FLASH_EMU_QUAD_EN
    assign spi_io_o  = r_o;
    assign spi_io_oe = r_oe;
`else
    assign spi_io_o  = {2'b00, r_o};
    assign spi_io_oe = {2'b00, r_oe};
`endif
    assign mem_addr   = r_mem_addr;
    assign mem_re     = r_mem_re;
    assign powered_up = r_powered_up;
    assign xip_active = r_xip_active;
endmodule

// File: tb/tb_spi_flash_emu.sv
// Directed bench for spi_flash_emu: a bit-banged SPI master and a memory returning byte[n] = n[7:0].
module tb_spi_flash_emu;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          spi_csn = 1'b1;
    logic          spi_clk = 1'b0;
    logic [3:0]    spi_io_i = 4'h0;
    logic [3:0]    spi_io_o, spi_io_oe;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic [7:0]    mem_rdata = 8'h00;
    logic          powered_up, xip_active;

    int n_checks = 0;
    int n_fail   = 0;

    spi_flash_emu #(.ADDR_WIDTH(AW), .DUMMY_FAST(8), .DUMMY_DUAL(0), .DUMMY_QUAD(4)) dut (
        .clk(clk), .rst_n(rst_n), .spi_csn(spi_csn), .spi_clk(spi_clk),
        .spi_io_i(spi_io_i), .spi_io_o(spi_io_o), .spi_io_oe(spi_io_oe),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .powered_up(powered_up), .xip_active(xip_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_re) mem_rdata <= mem_addr;

    // One SCK period of 16 clk; DUT outputs are sampled just before the rising edge.
    task automatic sck_bit(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] oe);
        spi_io_i = din;
        repeat (8) @(negedge clk);
        dout = spi_io_o;
        oe   = spi_io_oe;
        spi_clk = 1'b1;
        repeat (8) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic xfer(input int lanes, input logic [7:0] b, output logic [7:0] rx,
                        output logic [3:0] oe_or, output logic [3:0] oe_and);
        logic [7:0] sh;
        logic [3:0] d, o, e;
        sh = b; rx = 8'h00; oe_or = 4'h0; oe_and = 4'hF;
        for (int i = 0; i < 8 / lanes; i++) begin
            if (lanes == 1)      d = {3'b000, sh[7]};
            else if (lanes == 2) d = {2'b00, sh[7:6]};
            else                 d = sh[7:4];
            sh = sh << lanes;
            sck_bit(d, o, e);
            oe_or  = oe_or | e;
            oe_and = oe_and & e;
            if (lanes == 1)      rx = {rx[6:0], o[1]};
            else if (lanes == 2) rx = {rx[5:0], o[1:0]};
            else                 rx = {rx[3:0], o};
        end
    endtask

    task automatic send_addr(input int lanes, input logic [23:0] a, output logic [3:0] oe_or);
        logic [7:0] rx;
        logic [3:0] eo, ea;
        oe_or = 4'h0;
        for (int i = 2; i >= 0; i--) begin
            xfer(lanes, a[8*i +: 8], rx, eo, ea);
            oe_or = oe_or | eo;
        end
    endtask

    task automatic dummy(input int n, output logic [3:0] oe_or);
        logic [3:0] o, e;
        oe_or = 4'h0;
        for (int i = 0; i < n; i++) begin
            sck_bit(4'h0, o, e);
            oe_or = oe_or | e;
        end
    endtask

    task automatic cs_low();
        spi_csn = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        spi_csn = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (spi_io_o !== 4'h0)   begin n_fail++; $display("FAIL reset_io_o: got %h expected 0", spi_io_o); end
        n_checks++; if (spi_io_oe !== 4'h0)  begin n_fail++; $display("FAIL reset_oe: got %h expected 0", spi_io_oe); end
        n_checks++; if (mem_re !== 1'b0)     begin n_fail++; $display("FAIL reset_mem_re: got %b expected 0", mem_re); end
        n_checks++; if (mem_addr !== 8'h00)  begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 00", mem_addr); end
        n_checks++; if (powered_up !== 1'b1) begin n_fail++; $display("FAIL reset_powered_up: got %b expected 1", powered_up); end
        n_checks++; if (xip_active !== 1'b0) begin n_fail++; $display("FAIL reset_xip: got %b expected 0", xip_active); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_read();
        logic [7:0] rx;
        logic [3:0] eo, ea, acc, dor, dand;
        cs_low();
        xfer(1, 8'h03, rx, eo, ea); acc = eo;
        send_addr(1, 24'h000010, eo); acc = acc | eo;
        n_checks++; if (acc !== 4'h0) begin n_fail++; $display("FAIL read_oe_pre: got %h expected 0", acc); end
        dor = 4'h0; dand = 4'hF;
        for (int i = 0; i < 4; i++) begin
            xfer(1, 8'h00, rx, eo, ea);
            dor = dor | eo; dand = dand & ea;
            n_checks++;
            if (rx !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL read_byte%0d: got %h expected %h", i, rx, 8'(8'h10 + i)); end
        end
        n_checks++; if (dor !== 4'b0010)  begin n_fail++; $display("FAIL read_oe_or: got %b expected 0010", dor); end
        n_checks++; if (dand !== 4'b0010) begin n_fail++; $display("FAIL read_oe_and: got %b expected 0010", dand); end
        cs_high();
        n_checks++; if (spi_io_oe !== 4'h0) begin n_fail++; $display("FAIL read_oe_post: got %h expected 0", spi_io_oe); end
    endtask

    task automatic test_xip_dual();
        logic [7:0] rx;
        logic [7:0] exp [3];
        logic [3:0] eo, ea, acc;
        exp[0] = 8'hFE; exp[1] = 8'hFF; exp[2] = 8'h00;
        cs_low();
        xfer(1, 8'hBB, rx, eo, ea); acc = eo;
        send_addr(2, 24'h0000FE, eo); acc = acc | eo;
        xfer(2, 8'hA5, rx, eo, ea); acc = acc | eo;
        n_checks++; if (acc !== 4'h0) begin n_fail++; $display("FAIL xip_oe_pre: got %h expected 0", acc); end
        for (int i = 0; i < 3; i++) begin
            xfer(2, 8'h00, rx, eo, ea);
            n_checks++;
            if (rx !== exp[i]) begin n_fail++; $display("FAIL xip_byte%0d: got %h expected %h", i, rx, exp[i]); end
            n_checks++;
            if (eo !== 4'b0011 || ea !== 4'b0011) begin n_fail++; $display("FAIL xip_oe%0d: got %b/%b expected 0011", i, eo, ea); end
        end
        n_checks++; if (xip_active !== 1'b1) begin n_fail++; $display("FAIL xip_armed: got %b expected 1", xip_active); end
        cs_high();
        cs_low();
        send_addr(2, 24'h000020, eo);
        xfer(2, 8'h00, rx, eo, ea);
        xfer(2, 8'h00, rx, eo, ea);
        n_checks++; if (rx !== 8'h20) begin n_fail++; $display("FAIL xip_reentry_byte: got %h expected 20", rx); end
        n_checks++; if (xip_active !== 1'b0) begin n_fail++; $display("FAIL xip_disarm: got %b expected 0", xip_active); end
        cs_high();
    endtask

    task automatic test_quad();
        logic [7:0] rx;
        logic [3:0] eo, ea, acc;
`ifdef SPI_FLASH_EMU_QUAD_EN
        logic [7:0] exp [3];
        exp[0] = 8'hFE; exp[1] = 8'hFF; exp[2] = 8'h00;
        cs_low();
        xfer(1, 8'hEB, rx, eo, ea); acc = eo;
        send_addr(4, 24'h0000FE, eo); acc = acc | eo;
        xfer(4, 8'hA5, rx, eo, ea); acc = acc | eo;
        dummy(4, eo); acc = acc | eo;
        n_checks++; if (acc !== 4'h0) begin n_fail++; $display("FAIL quad_oe_pre: got %h expected 0", acc); end
        for (int i = 0; i < 3; i++) begin
            xfer(4, 8'h00, rx, eo, ea);
            n_checks++;
            if (rx !== exp[i] || ea !== 4'hF) begin n_fail++; $display("FAIL quad_byte%0d: got %h oe %b expected %h oe 1111", i, rx, ea, exp[i]); end
        end
        n_checks++; if (xip_active !== 1'b1) begin n_fail++; $display("FAIL quad_xip_armed: got %b expected 1", xip_active); end
        cs_high();
        cs_low();
        send_addr(4, 24'h000020, eo);
        xfer(4, 8'h00, rx, eo, ea);
        dummy(4, eo);
        xfer(4, 8'h00, rx, eo, ea);
        n_checks++; if (rx !== 8'h20) begin n_fail++; $display("FAIL quad_reentry_byte: got %h expected 20", rx); end
        n_checks++; if (xip_active !== 1'b0) begin n_fail++; $display("FAIL quad_xip_disarm: got %b expected 0", xip_active); end
        cs_high();
`else
        cs_low();
        xfer(1, 8'hEB, rx, eo, ea); acc = eo;
        send_addr(4, 24'h0000FE, eo); acc = acc | eo;
        xfer(4, 8'hA5, rx, eo, ea); acc = acc | eo;
        dummy(4, eo); acc = acc | eo;
        for (int i = 0; i < 3; i++) begin
            xfer(4, 8'h00, rx, eo, ea);
            acc = acc | eo;
        end
        n_checks++; if (acc !== 4'h0) begin n_fail++; $display("FAIL quad_disabled_oe: got %b expected 0000", acc); end
        n_checks++; if (xip_active !== 1'b0) begin n_fail++; $display("FAIL quad_disabled_xip: got %b expected 0", xip_active); end
        cs_high();
`endif
    endtask

    task automatic test_power();
        logic [7:0] rx;
        logic [3:0] eo, ea, acc;
        cs_low(); xfer(1, 8'hB9, rx, eo, ea); cs_high();
        n_checks++; if (powered_up !== 1'b0) begin n_fail++; $display("FAIL pd_flag: got %b expected 0", powered_up); end
        cs_low();
        xfer(1, 8'h03, rx, eo, ea); acc = eo;
        send_addr(1, 24'h000010, eo); acc = acc | eo;
        xfer(1, 8'h00, rx, eo, ea); acc = acc | eo;
        cs_high();
        n_checks++; if (acc !== 4'h0) begin n_fail++; $display("FAIL pd_read_oe: got %b expected 0000", acc); end
        cs_low(); xfer(1, 8'hAB, rx, eo, ea); cs_high();
        n_checks++; if (powered_up !== 1'b1) begin n_fail++; $display("FAIL pu_flag: got %b expected 1", powered_up); end
        cs_low();
        xfer(1, 8'h03, rx, eo, ea);
        send_addr(1, 24'h000022, eo);
        xfer(1, 8'h00, rx, eo, ea);
        cs_high();
        n_checks++; if (rx !== 8'h22) begin n_fail++; $display("FAIL pu_read_byte: got %h expected 22", rx); end
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        logic [3:0] o, eo, ea;
        cs_low();
        xfer(1, 8'hBB, rx, eo, ea);
        send_addr(2, 24'h000040, eo);
        xfer(2, 8'h00, rx, eo, ea);
        sck_bit(4'h0, o, eo);
        sck_bit(4'h0, o, eo);
        n_checks++; if (eo !== 4'b0011) begin n_fail++; $display("FAIL abort_oe_before: got %b expected 0011", eo); end
        spi_csn = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (spi_io_oe !== 4'h0) begin n_fail++; $display("FAIL abort_oe_after: got %b expected 0000", spi_io_oe); end
        repeat (5) @(negedge clk);
        cs_low();
        xfer(1, 8'h0B, rx, eo, ea);
        send_addr(1, 24'h000005, eo);
        dummy(8, eo);
        xfer(1, 8'h00, rx, eo, ea);
        cs_high();
        n_checks++; if (rx !== 8'h05) begin n_fail++; $display("FAIL fast_read_byte: got %h expected 05", rx); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        logic [3:0] o, eo, ea;
        cs_low();
        xfer(1, 8'hBB, rx, eo, ea);
        send_addr(2, 24'h000030, eo);
        xfer(2, 8'hA5, rx, eo, ea);
        xfer(2, 8'h00, rx, eo, ea);
        sck_bit(4'h0, o, eo);
        n_checks++; if (xip_active !== 1'b1 || rx !== 8'h30) begin n_fail++; $display("FAIL rmid_setup: got xip %b byte %h expected 1 30", xip_active, rx); end
        rst_n = 1'b0;
        #2;
        n_checks++; if (spi_io_oe !== 4'h0)  begin n_fail++; $display("FAIL rmid_oe: got %b expected 0000", spi_io_oe); end
        n_checks++; if (spi_io_o !== 4'h0)   begin n_fail++; $display("FAIL rmid_io_o: got %b expected 0000", spi_io_o); end
        n_checks++; if (mem_re !== 1'b0)     begin n_fail++; $display("FAIL rmid_mem_re: got %b expected 0", mem_re); end
        n_checks++; if (mem_addr !== 8'h00)  begin n_fail++; $display("FAIL rmid_mem_addr: got %h expected 00", mem_addr); end
        n_checks++; if (powered_up !== 1'b1) begin n_fail++; $display("FAIL rmid_powered_up: got %b expected 1", powered_up); end
        n_checks++; if (xip_active !== 1'b0) begin n_fail++; $display("FAIL rmid_xip: got %b expected 0", xip_active); end
        spi_csn = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        cs_low();
        xfer(1, 8'h03, rx, eo, ea);
        send_addr(1, 24'h000033, eo);
        xfer(1, 8'h00, rx, eo, ea);
        cs_high();
        n_checks++; if (rx !== 8'h33) begin n_fail++; $display("FAIL rmid_cmd_after_reset: got %h expected 33", rx); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_xip_dual();
        test_quad();
        test_power();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
